// File: rtl/sram_req_ctrl.sv
// Single-outstanding request sequencer in front of the board SRAM pin wrapper.
// Holds strobes for a fixed number of wait cycles, adds a turnaround after writes, and returns one response per request.
module sram_req_ctrl #(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1,
  parameter int SRAM_AW    = 20
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               io_req_valid,
  output logic               io_req_ready,
  input  logic [31:0]        io_req_addr,
  input  logic               io_req_we,
  input  logic [31:0]        io_req_wdata,
  input  logic [3:0]         io_req_wmask,
  output logic               io_resp_valid,
  input  logic               io_resp_ready,
  output logic [31:0]        io_resp_rdata,
  output logic               io_sram_en,
  output logic               io_sram_re,
  output logic               io_sram_we,
  output logic [SRAM_AW-1:0] io_sram_addr,
  output logic [31:0]        io_sram_din,
  output logic [3:0]         io_sram_wmask,
  input  logic [31:0]        io_sram_dout
);
  localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {IDLE, RD, WR, TURN, RESP} state_e;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [31:0]        wdata;
    logic [3:0]         wmask;
  } req_t;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] rdata_q, rdata_d;

  // Byte offset and bits above the SRAM window are dropped; aliasing is intended.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{io_req_addr[31:SRAM_AW+2], io_req_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (io_req_valid) begin
          req_d.addr  = io_req_addr[SRAM_AW+1:2];
          req_d.wdata = io_req_wdata;
          req_d.wmask = io_req_wmask;
          if (io_req_we) begin
            cnt_d   = CW'(WRITE_WAIT - 1);
            state_d = WR;
          end else begin
            cnt_d   = CW'(READ_WAIT - 1);
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rdata_d = io_sram_dout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR: begin
        if (cnt_q == '0) state_d = TURN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      TURN: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP: begin
        if (io_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Ready is masked while reset is held so nothing is accepted into a block being cleared.
  assign io_req_ready  = (state_q == IDLE) && resetn;
  assign io_resp_valid = (state_q == RESP);
  assign io_resp_rdata = rdata_q;
  assign io_sram_en    = (state_q == RD) || (state_q == WR);
  assign io_sram_re    = (state_q == RD);
  assign io_sram_we    = (state_q == WR);
  assign io_sram_addr  = req_q.addr;
  assign io_sram_din   = req_q.wdata;
  assign io_sram_wmask = (state_q == WR) ? req_q.wmask : 4'b0000;
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: SRAM wrapper model, transaction-timeline reference model, directed and random stimulus.
module tb_sram_req_ctrl;
  localparam int RW = 4;
  localparam int WW = 2;
  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          req_we = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wmask = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          sram_en, sram_re, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din;
  logic [3:0]    sram_wmask;
  logic [31:0]   sram_dout = 32'h0BADF00D;

  sram_req_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW), .SRAM_AW(AW)) dut (
    .clock(clock), .resetn(resetn),
    .io_req_valid(req_valid), .io_req_ready(req_ready), .io_req_addr(req_addr),
    .io_req_we(req_we), .io_req_wdata(req_wdata), .io_req_wmask(req_wmask),
    .io_resp_valid(resp_valid), .io_resp_ready(resp_ready), .io_resp_rdata(resp_rdata),
    .io_sram_en(sram_en), .io_sram_re(sram_re), .io_sram_we(sram_we),
    .io_sram_addr(sram_addr), .io_sram_din(sram_din), .io_sram_wmask(sram_wmask),
    .io_sram_dout(sram_dout)
  );

  always #5 clock = ~clock;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] wmem [int];
  logic [31:0] gmem [int];

  function automatic logic [31:0] dflt(input int w);
    if (w == 'h41) return 32'hDEADBEEF;
    if (w == 'h2)  return 32'hCAFEF00D;
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference: each request is a timeline of cycle offsets k after its accept edge.
  logic        m_busy = 1'b0;
  logic        m_we = 1'b0;
  int          m_k = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_wmask = '0;

  always @(posedge clock) begin
    int wi;
    cyc++;
    if (m_busy && m_we && m_k >= 1 && m_k <= WW) begin
      wi = int'(m_addr[AW+1:2]);
      gmem[wi] = merge(gmem.exists(wi) ? gmem[wi] : dflt(wi), m_wdata, m_wmask);
    end
    if (!resetn) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1; m_k = 1; m_we = req_we;
        m_addr = req_addr; m_wdata = req_wdata; m_wmask = req_wmask;
        wi = int'(req_addr[AW+1:2]);
        m_rdata = req_we ? 32'h0 : (gmem.exists(wi) ? gmem[wi] : dflt(wi));
      end
    end else if (m_k >= (m_we ? WW + 2 : RW + 1) && resp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
  end

  int last_we_cyc = 0;
  int rd_gap = 0;
  logic prev_re = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wrapper_step();
    int wi;
    wi = int'(sram_addr);
    if (sram_en && sram_we) begin
      wmem[wi] = merge(wmem.exists(wi) ? wmem[wi] : dflt(wi), sram_din, sram_wmask);
      last_we_cyc = cyc;
    end
    if (sram_en && sram_re) begin
      if (!prev_re) rd_gap = cyc - last_we_cyc;
      sram_dout = wmem.exists(wi) ? wmem[wi] : dflt(wi);
    end else begin
      sram_dout = 32'h0BADF00D;
    end
    prev_re = sram_re;
  endtask

  task automatic model_check();
    logic en_e, rv_e;
    en_e = m_busy && m_k >= 1 && m_k <= (m_we ? WW : RW);
    rv_e = m_busy && m_k >= (m_we ? WW + 2 : RW + 1);
    chk("req_ready", req_ready, resetn && !m_busy);
    chk("resp_valid", resp_valid, rv_e);
    chk("sram_en", sram_en, en_e);
    chk("sram_re", sram_re, en_e && !m_we);
    chk("sram_we", sram_we, en_e && m_we);
    if (en_e) begin
      chk("sram_addr", {12'h0, sram_addr}, {12'h0, m_addr[AW+1:2]});
      chk("sram_wmask", {28'h0, sram_wmask}, m_we ? {28'h0, m_wmask} : 32'h0);
      if (m_we) chk("sram_din", sram_din, m_wdata);
    end
    if (rv_e) chk("resp_rdata", resp_rdata, m_rdata);
  endtask

  task automatic go();
    @(posedge clock); #1;
  endtask

  task automatic step();
    @(posedge clock); #1;
    resp_ready = ($urandom_range(0, 3) != 0);
    resetn     = ($urandom_range(0, 79) != 0);
  endtask

  // Presents a request and returns at #1 after the accept edge (cycle k=1).
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit rnd);
    logic r;
    req_we = we; req_addr = a; req_wdata = d; req_wmask = m; req_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock); r = req_ready;
      if (rnd) step(); else go();
      if (r) begin req_valid = 1'b0; return; end
    end
    req_valid = 1'b0;
    n_run++; n_fail++;
    $display("FAIL accept_timeout: request at addr %h never accepted", a);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        wrapper_step();
        model_check();
      end
    join_none

    // reset values
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("rst_en", sram_en, 0); chk("rst_re", sram_re, 0); chk("rst_we", sram_we, 0);
      chk("rst_addr", {12'h0, sram_addr}, 0); chk("rst_din", sram_din, 0);
      chk("rst_wmask", {28'h0, sram_wmask}, 0); chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rdata", resp_rdata, 0); chk("rst_req_ready", req_ready, 0);
    end
    go(); resetn = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk("idle_req_ready", req_ready, 1); chk("idle_en", sram_en, 0);
    end
    go();

    // single read
    resp_ready = 1'b1;
    do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0);
    for (int k = 1; k <= RW + 1; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("rd_addr", {12'h0, sram_addr}, 32'h41); chk("rd_en", sram_en, 1); chk("rd_re", sram_re, 1);
      end
      if (k == RW + 1) begin
        chk("rd_resp_valid", resp_valid, 1); chk("rd_rdata", resp_rdata, 32'hDEADBEEF); chk("rd_en_off", sram_en, 0);
      end
      go();
    end

    // single write with partial mask
    do_req(1'b1, 32'h0000_0008, 32'h12345678, 4'b0011, 1'b0);
    for (int k = 1; k <= WW + 2; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("wr_en", sram_en, 1); chk("wr_we", sram_we, 1); chk("wr_re", sram_re, 0);
        chk("wr_addr", {12'h0, sram_addr}, 32'h2); chk("wr_din", sram_din, 32'h12345678);
        chk("wr_wmask", {28'h0, sram_wmask}, 32'h3);
      end
      if (k == WW) chk("wr_we_last", sram_we, 1);
      if (k == WW + 1) begin
        chk("turn_en", sram_en, 0); chk("turn_we", sram_we, 0); chk("turn_resp_valid", resp_valid, 0);
      end
      if (k == WW + 2) begin
        chk("wr_resp_valid", resp_valid, 1); chk("wr_rdata", resp_rdata, 0);
      end
      go();
    end

    // read back the masked write
    do_req(1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b0);
    for (int k = 1; k <= RW + 1; k++) begin
      @(negedge clock);
      if (k == RW + 1) chk("rb_rdata", resp_rdata, 32'hCAFE5678);
      go();
    end

    // write then read, back to back
    do_req(1'b1, 32'h0000_0010, 32'hA5A5A5A5, 4'hF, 1'b0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    for (int k = 1; k <= RW + 1; k++) begin
      @(negedge clock);
      if (k == 1) chk("wr_rd_gap", rd_gap, WW + 2);
      if (k == RW + 1) chk("b2b_rdata", resp_rdata, 32'hA5A5A5A5);
      go();
    end

    // response backpressure with a held follow-on request
    resp_ready = 1'b0;
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    for (int k = 1; k <= RW + 8; k++) begin
      if (k == RW + 1) begin req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0104; end
      if (k == RW + 6) resp_ready = 1'b1;
      if (k == RW + 8) req_valid = 1'b0;
      @(negedge clock);
      if (k >= RW + 1 && k <= RW + 5) begin
        chk("bp_resp_valid", resp_valid, 1); chk("bp_rdata", resp_rdata, 32'hA5A5A5A5);
        chk("bp_req_ready", req_ready, 0); chk("bp_en", sram_en, 0);
      end
      if (k == RW + 7) begin chk("bp_released_ready", req_ready, 1); chk("bp_released_valid", resp_valid, 0); end
      if (k == RW + 8) begin
        chk("bp_next_re", sram_re, 1); chk("bp_next_addr", {12'h0, sram_addr}, 32'h41);
      end
      go();
    end
    repeat (RW + 2) go();

    // reset during the second read cycle
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    @(negedge clock); go();
    resetn = 1'b0;
    @(negedge clock); chk("mid_rst_re_before", sram_re, 1);
    go(); resetn = 1'b1;
    @(negedge clock);
    chk("mid_rst_en", sram_en, 0); chk("mid_rst_re", sram_re, 0); chk("mid_rst_req_ready", req_ready, 1);
    repeat (8) begin
      @(negedge clock); chk("mid_rst_no_resp", resp_valid, 0);
    end
    go();

    // randomized traffic with random backpressure and occasional resets
    for (int t = 0; t < 300; t++) begin
      logic [19:0] widx;
      widx = {($urandom_range(0, 1) != 0) ? 4'hF : 4'h0, 12'h0, 4'($urandom_range(0, 15))};
      do_req(1'($urandom_range(0, 1)), {10'($urandom), widx, 2'($urandom)}, $urandom, 4'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    resetn = 1'b1; resp_ready = 1'b1;
    repeat (20) go();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Sequencer one stage upstream of the board SRAM pin wrapper.
- Accepts single-beat word read/write requests from the core/bus side over a valid/ready handshake.
- Drives the wrapper's io_sram_* strobes, address, data and mask for a parameterised number of wait cycles, inserts write-to-read bus turnaround, and returns the result over a valid/ready response channel.
- One outstanding request; no pipelining.

Parameters:
- READ_WAIT, 1, cycles io_sram_en/io_sram_re are held per read; legal values >= 1.
- WRITE_WAIT, 1, cycles io_sram_en/io_sram_we are held per write; legal values >= 1.
- SRAM_AW, 20, SRAM word-address width.

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous reset, active-low
- io_req_valid  in  1  request present
- io_req_ready  out  1  request accepted this cycle when valid&ready
- io_req_addr  in  32  byte address
- io_req_we  in  1  1 = write, 0 = read
- io_req_wdata  in  32  write data
- io_req_wmask  in  4  byte enables, active-high
- io_resp_valid  out  1  response present
- io_resp_ready  in  1  response consumed when valid&ready
- io_resp_rdata  out  32  read data; 0 for writes
- io_sram_en  out  1  access enable to wrapper
- io_sram_re  out  1  read strobe
- io_sram_we  out  1  write strobe
- io_sram_addr  out  SRAM_AW  word address
- io_sram_din  out  32  write data to wrapper
- io_sram_wmask  out  4  byte enables to wrapper
- io_sram_dout  in  32  read data from wrapper

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low.
- Reset values (resetn=0 at an edge):
  - state=IDLE.
  - io_req_ready=1 after reset release.
  - io_resp_valid=0, io_resp_rdata=0.
  - io_sram_en/re/we=0, io_sram_addr=0, io_sram_din=0, io_sram_wmask=0.
- States: IDLE, RD, WR, TURN, RESP.
- All io_sram_* and io_resp_* outputs are registered or decoded from state plus captured registers. Nothing combinational from io_req_* reaches them.
- IDLE:
  - io_req_ready=1; all strobes 0.
  - On valid&ready, capture addr, we, wdata, wmask.
  - Load counter with READ_WAIT-1 or WRITE_WAIT-1.
  - Go to RD (we=0) or WR (we=1).
- Address mapping: io_sram_addr = captured addr[SRAM_AW+1:2]. Bits [1:0] and bits above SRAM_AW+1 are ignored, so aliasing is by design.
- RD:
  - en=1, re=1, we=0, wmask=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, sample io_sram_dout into the rdata register, then go to RESP.
  - RD lasts exactly READ_WAIT cycles.
- WR:
  - en=1, we=1, re=0; din and wmask driven from captured registers.
  - Lasts exactly WRITE_WAIT cycles, then go to TURN.
- TURN:
  - One cycle with en/re/we=0. This lets the wrapper release the data bus before any following read.
  - Go to RESP.
  - rdata register cleared to 0.
- RESP:
  - io_resp_valid=1, io_req_ready=0; rdata held stable.
  - On io_resp_ready=1, go to IDLE.
  - Backpressure holds RESP indefinitely with strobes 0.
- io_req_ready=0 in every state except IDLE. Requests presented elsewhere are not accepted and must be held by the requester.
- Latency (accept edge = cycle T):
  - Read: strobes active T+1..T+READ_WAIT; resp_valid first at T+READ_WAIT+1.
  - Write: strobes active T+1..T+WRITE_WAIT; TURN at T+WRITE_WAIT+1; resp_valid at T+WRITE_WAIT+2.
- Throughput, with resp_ready tied high:
  - one read per READ_WAIT+2 cycles;
  - one write per WRITE_WAIT+3 cycles.
- A write with wmask=0 still runs the full WR/TURN sequence with io_sram_wmask=0 and still produces a response.
- Reset asserted mid-RD/WR/TURN/RESP: strobes are 0 on the next edge, the response is dropped, and state returns to IDLE. No partial response ever appears after reset.
- resp_valid and req_ready are never 1 in the same cycle.

Test Plan:
- Reset, then idle: resetn low 3 cycles -> all outputs 0. After release, io_req_ready=1 and io_sram_en=0 indefinitely with no request.
- Read, READ_WAIT=1: req addr=0x0000_0104, we=0 at T; wrapper model returns 0xDEADBEEF -> io_sram_addr=0x00041 with en=re=1 at T+1 only; resp_valid=1, rdata=0xDEADBEEF at T+2.
- Write, WRITE_WAIT=2: req addr=0x0000_0008, wdata=0x12345678, wmask=0b0011 -> en=we=1, addr=0x00002, din=0x12345678, wmask=0011 at T+1..T+2; all strobes 0 at T+3; resp_valid with rdata=0 at T+4.
- Write-then-read back-to-back, resp_ready=1: write 0xA5A5A5A5 to 0x10, then read 0x10 -> the read's re never overlaps we; at least one strobe-free cycle between them; read resp returns 0xA5A5A5A5.
- Backpressure: resp_ready=0 for 5 cycles after a read -> resp_valid stays 1, rdata stable, req_ready=0, strobes 0. A new req_valid is held and accepted only in the cycle after the response is consumed.
- Reset mid-access: READ_WAIT=4, drop resetn during the 2nd RD cycle -> en/re=0 on the next edge, resp_valid never asserts, req_ready=1 after release.
